// File: rtl/grid_cursor_ctrl_pkg.sv
// Shared definitions for the grid cursor controller.
//   - direction codes carried on the dir command field
//   - FSM state encoding (also exported on the debug state port)
//   - grid edge value for a 16x16 grid
package grid_cursor_ctrl_pkg;

  // dir[1] selects the axis (0 = X, 1 = Y); dir[0] selects subtract.
  localparam logic [1:0] DIR_PX = 2'd0;
  localparam logic [1:0] DIR_NX = 2'd1;
  localparam logic [1:0] DIR_PY = 2'd2;
  localparam logic [1:0] DIR_NY = 2'd3;

  localparam logic [3:0] GRID_MAX = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

endpackage

// File: rtl/grid_cursor_ctrl_adder5.sv
// adder5: 4-bit add/subtract stage with a 5th result bit.
//   pos  [3:0] in  : operand (current axis position)
//   step [1:0] in  : magnitude 0..3
//   op         in  : 0 = add, 1 = subtract
//   tmp  [3:0] out : result modulo 16
//   last       out : carry out. For add, 1 means the result passed 15.
//                    For subtract it is the inverted borrow, so 0 means
//                    pos < step.
module adder5 (
  input  logic [3:0] pos,
  input  logic [1:0] step,
  input  logic       op,
  output logic [3:0] tmp,
  output logic       last
);

  logic [4:0] addend;
  logic [4:0] sum;

  // Subtraction is done as pos + (16 - step); the carry out of that sum
  // is the "no borrow" flag. step = 0 yields an addend of 16 so the carry
  // is set and no edge is reported.
  always_comb begin
    addend = op ? (5'd16 - {3'b000, step}) : {3'b000, step};
    sum    = {1'b0, pos} + addend;
  end

  assign tmp  = sum[3:0];
  assign last = sum[4];

endmodule

// File: rtl/grid_cursor_ctrl.sv
// grid_cursor_ctrl: owns the X/Y cursor on a 16x16 grid and applies one
// move command at a time through the adder5 stage.
//   clk, rst_n        : clock, synchronous active-low reset
//   move_valid/ready  : command handshake
//   dir [1:0]         : 0 +X, 1 -X, 2 +Y, 3 -Y
//   step [1:0]        : move magnitude 0..3
//   home              : return to (0,0), honoured only while idle
//   pos_x/pos_y [3:0] : current position
//   done, hit_wall    : registered one-cycle pulses when a move commits
//   move_count        : number of accepted moves, wraps
//   fsm_state         : current controller state, for observation
//
// Handshake: a command transfers on a rising edge where move_valid and
// ready are both high. ready is combinational from state, home and rst_n;
// it is high only in IDLE, out of reset, with home low. Once a command is
// accepted, ready is low for exactly one cycle (CALC) and the result
// commits at the following edge.
module grid_cursor_ctrl
  import grid_cursor_ctrl_pkg::*;
#(
  parameter int WRAP  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             move_valid,
  input  logic [1:0]       dir,
  input  logic [1:0]       step,
  input  logic             home,
  output logic             ready,
  output logic [3:0]       pos_x,
  output logic [3:0]       pos_y,
  output logic             done,
  output logic             hit_wall,
  output logic [CNT_W-1:0] move_count,
  output state_t           fsm_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t     state, state_nxt;
  logic       accept;
  logic       lat_axis;
  logic       lat_op;
  logic [1:0] lat_step;
  logic [3:0] axis_pos;
  logic [3:0] sum;
  logic       carry;
  logic       wall;
  logic [3:0] commit_val;

  assign fsm_state = state;

  // Axis mux in front of the single adder5 instance.
  assign axis_pos = lat_axis ? pos_y : pos_x;

  adder5 u_adder5 (
    .pos  (axis_pos),
    .step (lat_step),
    .op   (lat_op),
    .tmp  (sum),
    .last (carry)
  );

  // Add crosses the edge on carry; subtract crosses it on borrow.
  assign wall = lat_op ? ~carry : carry;

  always_comb begin
    commit_val = sum;
    if (wall && (WRAP == 0)) begin
      commit_val = lat_op ? 4'd0 : GRID_MAX;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready  = rst_n & ~home;
        accept = move_valid & ready;
        if (accept) begin
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      done       <= 1'b0;
      hit_wall   <= 1'b0;
      move_count <= '0;
      lat_axis   <= 1'b0;
      lat_op     <= 1'b0;
      lat_step   <= 2'd0;
    end else begin
      state    <= state_nxt;
      done     <= 1'b0;
      hit_wall <= 1'b0;
      if (state == ST_IDLE) begin
        if (home) begin
          pos_x <= '0;
          pos_y <= '0;
        end else if (accept) begin
          lat_axis   <= dir[1];
          lat_op     <= dir[0];
          lat_step   <= step;
          move_count <= move_count + CNT_ONE;
        end
      end else begin
        if (lat_axis) begin
          pos_y <= commit_val;
        end else begin
          pos_x <= commit_val;
        end
        done     <= 1'b1;
        hit_wall <= wall;
      end
    end
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl. Two instances share the stimulus:
// dut0 saturates at the edge, dut1 wraps.
module tb_grid_cursor_ctrl;
  import grid_cursor_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       move_valid;
  logic [1:0] dir;
  logic [1:0] step;
  logic       home;

  logic       ready0, ready1, done0, done1, hw0, hw1;
  logic [3:0] x0, y0, x1, y1;
  logic [7:0] cnt0, cnt1;
  state_t     st0, st1;

  grid_cursor_ctrl #(.WRAP(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .dir(dir), .step(step),
    .home(home), .ready(ready0), .pos_x(x0), .pos_y(y0), .done(done0),
    .hit_wall(hw0), .move_count(cnt0), .fsm_state(st0)
  );

  grid_cursor_ctrl #(.WRAP(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .dir(dir), .step(step),
    .home(home), .ready(ready1), .pos_x(x1), .pos_y(y1), .done(done1),
    .hit_wall(hw1), .move_count(cnt1), .fsm_state(st1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full move on both instances, with hand-computed results.
  task automatic do_move(input string tag, input logic [1:0] d, input logic [1:0] s,
                         input logic [3:0] ex0, input logic [3:0] ey0, input logic ehw0,
                         input logic [3:0] ex1, input logic [3:0] ey1, input logic ehw1);
    move_valid = 1'b1;
    dir        = d;
    step       = s;
    #1;
    check({tag, ".ready_idle"}, ready0, 1);
    tick;
    move_valid = 1'b0;
    exp_cnt++;
    check({tag, ".ready_calc"}, ready0, 0);
    check({tag, ".done_early"}, done0, 0);
    check({tag, ".count"}, cnt0, exp_cnt);
    tick;
    check({tag, ".done0"}, done0, 1);
    check({tag, ".done1"}, done1, 1);
    check({tag, ".x0"}, x0, ex0);
    check({tag, ".y0"}, y0, ey0);
    check({tag, ".hw0"}, hw0, ehw0);
    check({tag, ".x1"}, x1, ex1);
    check({tag, ".y1"}, y1, ey1);
    check({tag, ".hw1"}, hw1, ehw1);
    check({tag, ".ready_back"}, ready0, 1);
  endtask

  task automatic do_home(input string tag);
    home = 1'b1;
    #1;
    check({tag, ".ready_home"}, ready0, 0);
    tick;
    home = 1'b0;
    check({tag, ".x0"}, x0, 0);
    check({tag, ".y0"}, y0, 0);
    check({tag, ".x1"}, x1, 0);
    check({tag, ".y1"}, y1, 0);
    check({tag, ".done"}, done0, 0);
    check({tag, ".count"}, cnt0, exp_cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; move_valid = 1'b0; dir = 2'd0; step = 2'd0; home = 1'b0;
    repeat (3) tick;
    check("rst.x", x0, 0);
    check("rst.y", y0, 0);
    check("rst.done", done0, 0);
    check("rst.hw", hw0, 0);
    check("rst.count", cnt0, 0);
    check("rst.ready", ready0, 0);
    check("rst.state", st0, ST_IDLE);
    rst_n = 1'b1;
    #1;
    check("rel.ready", ready0, 1);

    do_move("px3", DIR_PX, 2'd3, 4'd3, 4'd0, 1'b0, 4'd3, 4'd0, 1'b0);
    do_move("px3b", DIR_PX, 2'd3, 4'd6, 4'd0, 1'b0, 4'd6, 4'd0, 1'b0);
    do_move("px3c", DIR_PX, 2'd3, 4'd9, 4'd0, 1'b0, 4'd9, 4'd0, 1'b0);
    do_move("px3d", DIR_PX, 2'd3, 4'd12, 4'd0, 1'b0, 4'd12, 4'd0, 1'b0);
    do_move("px2", DIR_PX, 2'd2, 4'd14, 4'd0, 1'b0, 4'd14, 4'd0, 1'b0);
    // 14 + 3: saturate to 15 / wrap to 1
    do_move("px_edge", DIR_PX, 2'd3, 4'd15, 4'd0, 1'b1, 4'd1, 4'd0, 1'b1);
    do_home("home1");

    do_move("py1", DIR_PY, 2'd1, 4'd0, 4'd1, 1'b0, 4'd0, 4'd1, 1'b0);
    // 1 - 2: saturate to 0 / wrap to 15
    do_move("ny_edge", DIR_NY, 2'd2, 4'd0, 4'd0, 1'b1, 4'd0, 4'd15, 1'b1);
    do_home("home2");
    do_move("py2", DIR_PY, 2'd2, 4'd0, 4'd2, 1'b0, 4'd0, 4'd2, 1'b0);
    do_move("ny_exact", DIR_NY, 2'd2, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Back-to-back +Y step 1, move_valid held high for four moves.
    for (int i = 1; i <= 4; i++) exp_q.push_back(4'(i));
    move_valid = 1'b1; dir = DIR_PY; step = 2'd1;
    #1;
    check("b2b.ready0", ready0, 1);
    for (int e = 1; e <= 8; e++) begin
      tick;
      if (e % 2 == 1) begin
        exp_cnt++;
        check("b2b.ready_lo", ready0, 0);
        check("b2b.done_lo", done0, 0);
        check("b2b.count", cnt0, exp_cnt);
      end else begin
        logic [3:0] ey;
        ey = exp_q.pop_front();
        check("b2b.ready_hi", ready0, 1);
        check("b2b.done_hi", done0, 1);
        check("b2b.hw", hw0, 0);
        check("b2b.y0", y0, ey);
        check("b2b.y1", y1, ey);
      end
    end
    move_valid = 1'b0;
    check("b2b.count_final", cnt0, 4'd14);
    do_home("home3");

    do_move("to57a", DIR_PX, 2'd3, 4'd3, 4'd0, 1'b0, 4'd3, 4'd0, 1'b0);
    do_move("to57b", DIR_PX, 2'd2, 4'd5, 4'd0, 1'b0, 4'd5, 4'd0, 1'b0);
    do_move("to57c", DIR_PY, 2'd3, 4'd5, 4'd3, 1'b0, 4'd5, 4'd3, 1'b0);
    do_move("to57d", DIR_PY, 2'd3, 4'd5, 4'd6, 1'b0, 4'd5, 4'd6, 1'b0);
    do_move("to57e", DIR_PY, 2'd1, 4'd5, 4'd7, 1'b0, 4'd5, 4'd7, 1'b0);

    // home together with a valid command: home wins, nothing accepted
    move_valid = 1'b1; dir = DIR_PX; step = 2'd1;
    do_home("home_mv");
    move_valid = 1'b0;
    tick;
    check("home_mv.no_done", done0, 0);
    check("home_mv.count", cnt0, exp_cnt);
    check("home_mv.x", x0, 0);

    do_move("px2_again", DIR_PX, 2'd2, 4'd2, 4'd0, 1'b0, 4'd2, 4'd0, 1'b0);
    do_move("nx0", DIR_NX, 2'd0, 4'd2, 4'd0, 1'b0, 4'd2, 4'd0, 1'b0);
    check("total.count1", cnt1, exp_cnt);

    // Reset while a move is in CALC: discarded, outputs return to reset values.
    move_valid = 1'b1; dir = DIR_PX; step = 2'd1;
    tick;
    move_valid = 1'b0;
    check("rcalc.state", st0, ST_CALC);
    rst_n = 1'b0;
    tick;
    check("rcalc.done", done0, 0);
    check("rcalc.x", x0, 0);
    check("rcalc.y", y0, 0);
    check("rcalc.count", cnt0, 0);
    check("rcalc.ready_low", ready0, 0);
    check("rcalc.state_idle", st0, ST_IDLE);
    rst_n = 1'b1;
    #1;
    check("rcalc.ready_rel", ready0, 1);
    tick;
    check("rcalc.no_done", done0, 0);
    check("rcalc.x_after", x0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
